// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS 7:1 receive phase-alignment block.
//   PHASE_STEPS    : number of PLL dynamic phase codes swept
//   PSDA_W         : width of the psda phase code
//   TRAIN_WORD_DEF : default training word expected on every channel
//   state_t        : controller state encoding
package lvds_rx_pkg;

  localparam int unsigned PHASE_STEPS    = 16;
  localparam int unsigned PSDA_W         = 4;
  localparam logic [6:0]  TRAIN_WORD_DEF = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SET_PHASE = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CHECK     = 3'd3,
    ST_NEXT      = 3'd4,
    ST_ANALYZE   = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

endpackage

// File: rtl/lvds_eye_search.sv
// Sequential circular longest-run search over a 16-bit pass map.
// A start pulse begins a 32-cycle scan (map concatenated with itself, one bit
// per cycle, the first bit consumed in the start cycle). done is asserted
// combinationally in the cycle that consumes the last bit, with width/center
// valid in that same cycle.
//   clk    in  : clock, rising edge
//   reset  in  : synchronous, active-high
//   start  in  : pulse, begin a new scan
//   map    in  : pass map, bit p = phase p passed
//   done   out : final scan cycle, width/center valid
//   width  out : longest run of 1s, capped at 16
//   center out : (run start + width/2) mod 16
module lvds_eye_search
  import lvds_rx_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PHASE_STEPS-1:0] map,
  output logic                   done,
  output logic [4:0]             width,
  output logic [PSDA_W-1:0]      center
);

  localparam logic [4:0] LEN_MAX  = 5'(PHASE_STEPS);
  localparam logic [4:0] IDX_LAST = 5'(2 * PHASE_STEPS - 1);

  logic              running;
  logic [4:0]        idx;
  logic [4:0]        cur_len;
  logic [PSDA_W-1:0] cur_start;
  logic [4:0]        best_len;
  logic [PSDA_W-1:0] best_start;

  logic              active;
  logic [4:0]        e_idx;
  logic [4:0]        e_cur_len;
  logic [PSDA_W-1:0] e_cur_start;
  logic [4:0]        e_best_len;
  logic [PSDA_W-1:0] e_best_start;
  logic [4:0]        n_cur_len;
  logic [PSDA_W-1:0] n_cur_start;
  logic [4:0]        n_best_len;
  logic [PSDA_W-1:0] n_best_start;

  // The start cycle works on a fresh scan state so that it already consumes bit 0.
  always_comb begin
    active       = start | running;
    e_idx        = start ? '0 : idx;
    e_cur_len    = start ? '0 : cur_len;
    e_cur_start  = start ? '0 : cur_start;
    e_best_len   = start ? '0 : best_len;
    e_best_start = start ? '0 : best_start;

    n_cur_len   = '0;
    n_cur_start = e_cur_start;
    if (map[e_idx[PSDA_W-1:0]]) begin
      if (e_cur_len == '0) begin
        n_cur_start = e_idx[PSDA_W-1:0];
      end
      n_cur_len = (e_cur_len == LEN_MAX) ? e_cur_len : e_cur_len + 5'd1;
    end

    // Strictly longer only: the earliest start keeps ties.
    n_best_len   = e_best_len;
    n_best_start = e_best_start;
    if (n_cur_len > e_best_len) begin
      n_best_len   = n_cur_len;
      n_best_start = n_cur_start;
    end

    done   = active && (e_idx == IDX_LAST);
    width  = n_best_len;
    center = n_best_start + n_best_len[4:1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running    <= 1'b0;
      idx        <= '0;
      cur_len    <= '0;
      cur_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
    end else if (active) begin
      running    <= (e_idx != IDX_LAST);
      idx        <= e_idx + 5'd1;
      cur_len    <= n_cur_len;
      cur_start  <= n_cur_start;
      best_len   <= n_best_len;
      best_start <= n_best_start;
    end
  end

endmodule

// File: rtl/lvds_rx_phase_align.sv
// Automatic phase-training controller for the LVDS 7:1 receive PLL.
// Sweeps psda over all 16 phase codes, checks the training word on every
// channel at each step, then centres psda in the widest circular pass window.
//   clkin      in  : pixel clock, rising edge
//   reset      in  : synchronous, active-high
//   pll_lock   in  : rPLL lock (already synchronised)
//   rx_data    in  : deserialised words, channel 0 in LSBs
//   retrain    in  : pulse, restart sweep from DONE/FAIL
//   psda       out : PLL dynamic phase code
//   dutyda     out : PLL duty code (constant)
//   fdly       out : PLL fine delay (constant)
//   busy       out : sweep or analysis in progress
//   align_done out : psda centred in a window of at least MIN_EYE
//   align_fail out : no window of at least MIN_EYE
//   eye_width  out : width of chosen window
//   eye_center out : chosen psda code
//   pass_map   out : bit p set when phase p passed
module lvds_rx_phase_align
  import lvds_rx_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 5,
  parameter int unsigned       WORD_W     = 7,
  parameter logic [WORD_W-1:0] TRAIN_WORD = TRAIN_WORD_DEF,
  parameter int unsigned       SETTLE_CYC = 64,
  parameter int unsigned       CHECK_CYC  = 256,
  parameter int unsigned       MIN_EYE    = 3,
  parameter logic [3:0]        DUTY_CODE  = 4'b1000,
  parameter logic [3:0]        FDLY_CODE  = 4'b0000
) (
  input  logic                     clkin,
  input  logic                     reset,
  input  logic                     pll_lock,
  input  logic [NUM_CH*WORD_W-1:0] rx_data,
  input  logic                     retrain,
  output logic [3:0]               psda,
  output logic [3:0]               dutyda,
  output logic [3:0]               fdly,
  output logic                     busy,
  output logic                     align_done,
  output logic                     align_fail,
  output logic [4:0]               eye_width,
  output logic [3:0]               eye_center,
  output logic [15:0]              pass_map
);

  localparam int unsigned      MAX_CYC     = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
  localparam int unsigned      CNT_W       = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYC - 1);
  localparam logic [4:0]       MIN_W       = 5'(MIN_EYE);
  localparam logic [3:0]       LAST_PHASE  = 4'(PHASE_STEPS - 1);

  state_t              state;
  logic [PSDA_W-1:0]   phase;
  logic [CNT_W-1:0]    cnt;
  logic                err;
  logic                srch_start;
  logic                word_bad;
  logic                sweep_go;
  logic                srch_done;
  logic [4:0]          srch_width;
  logic [PSDA_W-1:0]   srch_center;

  assign dutyda = DUTY_CODE;
  assign fdly   = FDLY_CODE;

  always_comb begin
    word_bad = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rx_data[c*WORD_W +: WORD_W] != TRAIN_WORD) begin
        word_bad = 1'b1;
      end
    end
  end

  always_comb begin
    busy = (state == ST_SET_PHASE) || (state == ST_SETTLE) || (state == ST_CHECK) ||
           (state == ST_NEXT) || (state == ST_ANALYZE);
    // IDLE starts on lock, DONE/FAIL on retrain; lock is known high here.
    sweep_go = (state == ST_IDLE) ? pll_lock : retrain;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      srch_start <= 1'b0;
      psda       <= '0;
      align_done <= 1'b0;
      align_fail <= 1'b0;
      eye_width  <= '0;
      eye_center <= '0;
      pass_map   <= '0;
    end else begin
      srch_start <= 1'b0;
      if ((state != ST_IDLE) && !pll_lock) begin
        // Lock loss aborts: psda and the partial pass_map are left as they are.
        state      <= ST_IDLE;
        err        <= 1'b0;
        align_done <= 1'b0;
        align_fail <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (sweep_go) begin
              state      <= ST_SET_PHASE;
              phase      <= '0;
              err        <= 1'b0;
              pass_map   <= '0;
              align_done <= 1'b0;
              align_fail <= 1'b0;
            end
          end
          ST_SET_PHASE: begin
            psda  <= phase;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              state <= ST_CHECK;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_CHECK: begin
            err <= err | word_bad;
            if (cnt == CHECK_LAST) begin
              state <= ST_NEXT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_NEXT: begin
            pass_map[phase] <= ~err;
            err             <= 1'b0;
            if (phase == LAST_PHASE) begin
              state      <= ST_ANALYZE;
              srch_start <= 1'b1;
            end else begin
              phase <= phase + 4'd1;
              state <= ST_SET_PHASE;
            end
          end
          ST_ANALYZE: begin
            if (srch_done) begin
              eye_width  <= srch_width;
              eye_center <= srch_center;
              if (srch_width >= MIN_W) begin
                state      <= ST_DONE;
                psda       <= srch_center;
                align_done <= 1'b1;
              end else begin
                state      <= ST_FAIL;
                psda       <= '0;
                align_fail <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  lvds_eye_search u_eye_search (
    .clk    (clkin),
    .reset  (reset),
    .start  (srch_start),
    .map    (pass_map),
    .done   (srch_done),
    .width  (srch_width),
    .center (srch_center)
  );

endmodule

// File: tb/tb_lvds_rx_phase_align.sv
module tb_lvds_rx_phase_align;

  localparam int NUM_CH   = 5;
  localparam int WORD_W   = 7;
  localparam int S        = 8;
  localparam int C        = 16;
  localparam int MIN_EYE  = 3;
  localparam int PER      = S + C + 2;
  localparam int SWEEP    = 16 * PER;
  localparam int DONE_LAT = SWEEP + 32;
  localparam logic [WORD_W-1:0] TW = 7'b1100011;

  logic                     clk;
  logic                     reset;
  logic                     pll_lock;
  logic [NUM_CH*WORD_W-1:0] rx_data;
  logic                     retrain;
  logic [3:0]               psda;
  logic [3:0]               dutyda;
  logic [3:0]               fdly;
  logic                     busy;
  logic                     align_done;
  logic                     align_fail;
  logic [4:0]               eye_width;
  logic [3:0]               eye_center;
  logic [15:0]              pass_map;

  lvds_rx_phase_align #(
    .NUM_CH     (NUM_CH),
    .WORD_W     (WORD_W),
    .TRAIN_WORD (TW),
    .SETTLE_CYC (S),
    .CHECK_CYC  (C),
    .MIN_EYE    (MIN_EYE),
    .DUTY_CODE  (4'b1000),
    .FDLY_CODE  (4'b0000)
  ) dut (
    .clkin      (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .rx_data    (rx_data),
    .retrain    (retrain),
    .psda       (psda),
    .dutyda     (dutyda),
    .fdly       (fdly),
    .busy       (busy),
    .align_done (align_done),
    .align_fail (align_fail),
    .eye_width  (eye_width),
    .eye_center (eye_center),
    .pass_map   (pass_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] map;
    int          width;
    int          center;
    bit          ok;
    int          when;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] good = '0;
  int          sweep_t0 = -1000000;
  int          bad_off[16];
  int          bad_ch[16];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: longest circular run found by trying every start phase.
  function automatic exp_t model(input logic [15:0] g, input int when);
    exp_t e;
    int   best_len = 0;
    int   best_s   = 0;
    for (int s = 0; s < 16; s++) begin
      int len = 0;
      while (len < 16 && g[(s + len) % 16]) len++;
      if (len > best_len) begin
        best_len = len;
        best_s   = s;
      end
    end
    e.map    = g;
    e.width  = best_len;
    e.center = (best_s + best_len / 2) % 16;
    e.ok     = (best_len >= MIN_EYE);
    e.when   = when;
    return e;
  endfunction

  // Link model: the data seen in each cycle depends on where the sweep is.
  // Ignored windows get garbage; bad phases get at least one wrong word.
  always @(negedge clk) begin
    int t, ph, w, cw;
    logic [WORD_W-1:0] wd;
    logic [NUM_CH*WORD_W-1:0] d;
    t = cyc - sweep_t0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wd = ($urandom_range(1) == 1) ? WORD_W'($urandom) : TW;
      if (t >= 0 && t < SWEEP) begin
        ph = t / PER;
        w  = t % PER;
        if (w >= S + 1 && w <= S + C) begin
          cw = w - (S + 1);
          wd = TW;
          if (!good[ph]) begin
            if (cw == bad_off[ph] && ch == bad_ch[ph])
              wd = wd ^ WORD_W'($urandom_range(127, 1));
            if ($urandom_range(7) == 0)
              wd = wd ^ WORD_W'($urandom_range(127, 1));
          end
        end
      end
      d[ch*WORD_W +: WORD_W] = wd;
    end
    rx_data = d;
  end

  // Monitor: each new done/fail result is checked against the queued expectation.
  logic prev_flag = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && (align_done || align_fail) && !prev_flag) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got result at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.when);
        chk("align_done", int'(align_done), int'(e.ok));
        chk("align_fail", int'(align_fail), int'(!e.ok));
        chk("eye_width", int'(eye_width), e.width);
        chk("eye_center", int'(eye_center), e.center);
        chk("psda", int'(psda), e.ok ? e.center : 0);
        chk("pass_map", int'(pass_map), int'(e.map));
        chk("busy_after", int'(busy), 0);
      end
    end
    prev_flag = align_done || align_fail;
  end

  task automatic new_pattern(input logic [15:0] g);
    good = g;
    for (int p = 0; p < 16; p++) begin
      bad_off[p] = $urandom_range(C - 1);
      bad_ch[p]  = $urandom_range(NUM_CH - 1);
    end
  endtask

  task automatic trig_lock();
    @(negedge clk);
    pll_lock = 1'b1;
    sweep_t0 = cyc + 1;
    sbq.push_back(model(good, sweep_t0 + DONE_LAT));
  endtask

  task automatic trig_retrain();
    @(negedge clk);
    retrain  = 1'b1;
    sweep_t0 = cyc + 1;
    sbq.push_back(model(good, sweep_t0 + DONE_LAT));
    @(negedge clk);
    retrain = 1'b0;
  endtask

  task automatic wait_result();
    int k = 0;
    while (sbq.size() != 0 && k < DONE_LAT + 100) begin
      @(posedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL result_timeout: got no result after %0d cycles expected one", k);
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_psda"}, int'(psda), 0);
    chk({tag, "_dutyda"}, int'(dutyda), 8);
    chk({tag, "_fdly"}, int'(fdly), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(align_done), 0);
    chk({tag, "_fail"}, int'(align_fail), 0);
    chk({tag, "_width"}, int'(eye_width), 0);
    chk({tag, "_center"}, int'(eye_center), 0);
    chk({tag, "_map"}, int'(pass_map), 0);
  endtask

  logic [15:0] pats[9];

  initial begin
    int target;
    reset    = 1'b1;
    pll_lock = 1'b0;
    retrain  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_unlocked_busy", int'(busy), 0);

    // Centred window 4..11, started by lock.
    new_pattern(16'h0FF0);
    trig_lock();
    wait_result();

    pats[0] = 16'hC007;   // wrap 14..2
    pats[1] = 16'hFFFF;   // all pass
    pats[2] = 16'h0018;   // too narrow
    pats[3] = 16'h0E0E;   // tie 1..3 / 9..11
    pats[4] = 16'hFFBF;   // only phase 6 bad
    for (int i = 5; i < 9; i++)
      pats[i] = 16'($urandom) | 16'($urandom);

    for (int i = 0; i < 9; i++) begin
      new_pattern(pats[i]);
      trig_retrain();
      if (i == 0) begin
        // Retrain while busy must not restart; done_cycle would move.
        repeat (100) @(negedge clk);
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
      end
      wait_result();
    end

    // Lock loss in CHECK of phase 9.
    new_pattern(16'h01B5);
    trig_retrain();
    target = sweep_t0 + 9 * PER + S + 1 + $urandom_range(C - 1);
    while (cyc < target) @(negedge clk);
    sbq.delete();
    pll_lock = 1'b0;
    sweep_t0 = -1000000;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(align_done), 0);
    chk("abort_fail", int'(align_fail), 0);
    chk("abort_psda", int'(psda), 9);
    chk("abort_map", int'(pass_map), int'(good & 16'h01FF));
    repeat (5) @(negedge clk);
    chk("unlocked_busy", int'(busy), 0);

    new_pattern(16'h03F8);
    trig_lock();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("relock_psda", int'(psda), 0);
    chk("relock_busy", int'(busy), 1);
    wait_result();

    // Reset wins over a simultaneous retrain.
    @(negedge clk);
    reset   = 1'b1;
    retrain = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("reset_retrain");
    @(negedge clk);
    retrain  = 1'b0;
    pll_lock = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
